pkt_attr_select_queue: RTL and testbench
========================================

Name: pkt_attr_select_queue

Overview:
- Parametrised successor stage for the packet analyzer result path. It takes the per-protocol-combination {valid, attribute} vectors from the protocol parsers and selects one winner per cycle by fixed priority, with a runtime per-group enable mask.
- The winner is tagged with its group id and buffered in a small FIFO with a valid/ready output handshake. Per-group hit counters and a drop counter are kept for the monitoring register block.
- It replaces the unbuffered, always-ready priority mux with a backpressure-capable interface.

Parameters:
- NUM_GROUPS, 4, number of protocol-combination result groups (2..32).
- ATTRIBUTE_DATA_WIDTH, 135, width of one attribute record.
- FIFO_DEPTH, 8, output buffer entries; power of two, >=2.
- CNT_WIDTH, 32, width of hit/drop counters.
- GID_WIDTH, log2(NUM_GROUPS), width of group id and counter select.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- valid_groups_i  in  NUM_GROUPS  per-group result valid, 1-cycle pulse.
- data_groups_i  in  NUM_GROUPS*ATTRIBUTE_DATA_WIDTH  group g at bits [g*ADW +: ADW].
- group_en_i  in  NUM_GROUPS  runtime enable mask; 0 ignores that group.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  ATTRIBUTE_DATA_WIDTH  head attribute record.
- out_group_id  out  GID_WIDTH  index of the winning group.
- fifo_level  out  log2(FIFO_DEPTH)+1  current occupancy.
- clr_cnt_i  in  1  synchronous clear of all counters.
- hit_cnt_sel_i  in  GID_WIDTH  counter read select.
- hit_cnt_o  out  CNT_WIDTH  hit count of the selected group (combinational read).
- drop_cnt_o  out  CNT_WIDTH  records dropped because the FIFO was full.

Behaviour:
- Reset (async, active-high): FIFO pointers/level=0, out_valid=0, out_data=0, out_group_id=0, all counters=0, selection register invalid. Reset mid-packet discards everything buffered and in flight.
- Stage 1 (registered): hit = valid_groups_i & group_en_i.
  - If hit!=0, the lowest set index wins. Register sel_valid=1, sel_data=that group's slice, sel_gid=index.
  - Else sel_valid=0.
  - Multiple simultaneous hits: only the lowest index is forwarded. The others are neither counted nor queued.
- Stage 2 (FIFO write): when sel_valid, push {sel_gid, sel_data}.
  - Full and no pop in the same cycle: drop the record; drop_cnt_o += 1.
  - Full with a pop (out_valid & out_ready) in the same cycle: the push succeeds and level stays FIFO_DEPTH.
- Output: first-word-fall-through.
  - out_valid = (level!=0); out_data and out_group_id show the head.
  - Pop on out_valid & out_ready.
  - out_data/out_group_id must hold stable while out_valid & !out_ready.
  - Empty with push: no pop in that cycle; the head appears the next cycle.
- Latency: input valid at cycle N -> out_valid=1 at N+2 when the FIFO is empty. Sustained throughput is 1 record/cycle with out_ready=1.
- Pointer wrap: natural modulo FIFO_DEPTH. Level is kept as a separate counter (0..FIFO_DEPTH).
- Counters:
  - hit_cnt[g] increments when stage 1 registers a winner g, even if it is later dropped.
  - All counters saturate at 2^CNT_WIDTH-1.
  - clr_cnt_i zeros all counters next cycle and takes precedence over a same-cycle increment.
  - hit_cnt_sel_i >= NUM_GROUPS returns 0.
- group_en_i is sampled every cycle with no retiming. Disabling a group does not flush entries already queued.

Decomposition:
- Shared package: log2 function, GID_WIDTH/level-width derivations, CNT_WIDTH default, and the attribute field offsets {input_port, prtcl_id, pkt_flags, bytes, l4 dst, l4 src, dst ip, src ip, proto} used downstream.
- One sub-module, attr_sync_fifo: FWFT synchronous FIFO with parameters WIDTH=GID_WIDTH+ATTRIBUTE_DATA_WIDTH and DEPTH=FIFO_DEPTH, level output, and push-when-full-with-pop support.
- Priority encode and counters stay in the top.

Test Plan:
- Single hit: group 2 valid, en=4'b1111, out_ready=1 -> out_valid at N+2 with group 2's data, out_group_id=2, hit_cnt[2]=1, drop_cnt=0.
- Multi-hit with mask: valid=4'b1110, en=4'b1101 -> winner group 2 (group 1 masked). hit_cnt[1]=0, hit_cnt[2]=1, hit_cnt[3]=0.
- Backpressure/full: out_ready=0, 10 consecutive hits with FIFO_DEPTH=8 -> level=8, drop_cnt=2. Then out_ready=1 drains the 8 records in order.
- Push while full with pop: FIFO full, out_ready=1 and a new hit in the same cycle -> level stays 8, drop_cnt unchanged, the new record is last out.
- Counter saturation/clear: CNT_WIDTH=4, 20 hits on group 0 -> hit_cnt[0]=15. clr_cnt_i coincident with a hit -> hit_cnt[0]=0. hit_cnt_sel_i=5 with NUM_GROUPS=4 -> 0.
- Async reset mid-stream: assert reset with level=5 -> out_valid=0, fifo_level=0 and counters=0 immediately, no clock edge required.

Source files
------------

// File: rtl/pkt_attr_select_queue_pkg.sv
// Shared definitions for the packet attribute select queue: sizing helpers,
// defaults and the attribute record layout used by downstream consumers.
package pkt_attr_select_queue_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

  localparam int unsigned DEF_NUM_GROUPS  = 4;
  localparam int unsigned DEF_ATTR_WIDTH  = 135;
  localparam int unsigned DEF_FIFO_DEPTH  = 8;
  localparam int unsigned DEF_CNT_WIDTH   = 32;

  // Attribute record field offsets (LSB first) for the default 135-bit record
  localparam int unsigned OFS_PROTO      = 0;
  localparam int unsigned OFS_SRC_IP     = 8;
  localparam int unsigned OFS_DST_IP     = 40;
  localparam int unsigned OFS_L4_SRC     = 72;
  localparam int unsigned OFS_L4_DST     = 88;
  localparam int unsigned OFS_BYTES      = 104;
  localparam int unsigned OFS_PKT_FLAGS  = 120;
  localparam int unsigned OFS_PRTCL_ID   = 128;
  localparam int unsigned OFS_INPUT_PORT = 132;

  typedef struct packed {
    logic [2:0]  input_port;
    logic [3:0]  prtcl_id;
    logic [7:0]  pkt_flags;
    logic [15:0] bytes;
    logic [15:0] l4_dst;
    logic [15:0] l4_src;
    logic [31:0] dst_ip;
    logic [31:0] src_ip;
    logic [7:0]  proto;
  } attr_t;

endpackage

// File: rtl/pkt_attr_select_queue_if.sv
// Output handshake of the select queue: FWFT head with valid/ready.
interface pkt_attr_select_queue_if #(
  parameter int unsigned ADW = 135,
  parameter int unsigned GW  = 2
);
  logic           out_valid;
  logic           out_ready;
  logic [ADW-1:0] out_data;
  logic [GW-1:0]  out_group_id;

  modport master (output out_valid, output out_data, output out_group_id, input  out_ready);
  modport slave  (input  out_valid, input  out_data, input  out_group_id, output out_ready);
endinterface

// File: rtl/pkt_attr_select_queue_attr_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy counter; a push into
// a full FIFO succeeds when a pop happens in the same cycle.
module attr_sync_fifo
  import pkt_attr_select_queue_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full_c,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full_c  = (level == LVL_W'(DEPTH));
  assign pop_ok  = pop && (level != '0);
  assign push_ok = push && (!full_c || pop_ok);
  // Empty FIFO presents zero rather than stale storage
  assign rdata_c = (level != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop_ok)      level <= level + LVL_W'(1);
      else if (!push_ok && pop_ok) level <= level - LVL_W'(1);
    end
  end

endmodule

// File: rtl/pkt_attr_select_queue.sv
// Fixed-priority winner select across protocol result groups, buffered in a
// FWFT queue with valid/ready output, plus saturating hit/drop counters.
module pkt_attr_select_queue
  import pkt_attr_select_queue_pkg::*;
#(
  parameter int unsigned NUM_GROUPS           = DEF_NUM_GROUPS,
  parameter int unsigned ATTRIBUTE_DATA_WIDTH = DEF_ATTR_WIDTH,
  parameter int unsigned FIFO_DEPTH           = DEF_FIFO_DEPTH,
  parameter int unsigned CNT_WIDTH            = DEF_CNT_WIDTH,
  localparam int unsigned GID_WIDTH           = clog2(NUM_GROUPS),
  localparam int unsigned LVL_WIDTH           = clog2(FIFO_DEPTH) + 1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_GROUPS-1:0]                      valid_groups_i,
  input  logic [NUM_GROUPS*ATTRIBUTE_DATA_WIDTH-1:0] data_groups_i,
  input  logic [NUM_GROUPS-1:0]                      group_en_i,
  pkt_attr_select_queue_if.master                    out_if,
  output logic [LVL_WIDTH-1:0]                       fifo_level,
  input  logic                                       clr_cnt_i,
  input  logic [GID_WIDTH-1:0]                       hit_cnt_sel_i,
  output logic [CNT_WIDTH-1:0]                       hit_cnt_o,
  output logic [CNT_WIDTH-1:0]                       drop_cnt_o
);

  localparam int unsigned ADW = ATTRIBUTE_DATA_WIDTH;
  localparam int unsigned FW  = GID_WIDTH + ADW;

  logic [NUM_GROUPS-1:0] hit;
  logic                  win_valid;
  logic [GID_WIDTH-1:0]  win_gid;
  logic [ADW-1:0]        win_data;
  logic                  sel_valid;
  logic [GID_WIDTH-1:0]  sel_gid;
  logic [ADW-1:0]        sel_data;
  logic [FW-1:0]         fifo_rdata;
  logic                  fifo_full;
  logic                  pop;
  logic [CNT_WIDTH-1:0]  hit_cnt [NUM_GROUPS];

  // Lowest enabled index wins; scanning downward leaves it as the last write
  always_comb begin
    hit       = valid_groups_i & group_en_i;
    win_valid = 1'b0;
    win_gid   = '0;
    win_data  = '0;
    for (int g = NUM_GROUPS - 1; g >= 0; g--) begin
      if (hit[g]) begin
        win_valid = 1'b1;
        win_gid   = GID_WIDTH'(g);
        win_data  = data_groups_i[g*ADW +: ADW];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_valid <= 1'b0;
      sel_gid   <= '0;
      sel_data  <= '0;
    end else begin
      sel_valid <= win_valid;
      sel_gid   <= win_gid;
      sel_data  <= win_data;
    end
  end

  assign pop = out_if.out_valid && out_if.out_ready;

  attr_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (sel_valid),
    .wdata   ({sel_gid, sel_data}),
    .pop     (pop),
    .rdata_c (fifo_rdata),
    .full_c  (fifo_full),
    .level   (fifo_level)
  );

  assign out_if.out_valid = (fifo_level != '0);
  assign {out_if.out_group_id, out_if.out_data} = fifo_rdata;

  // Hits count at selection time, so dropped winners still count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int g = 0; g < NUM_GROUPS; g++) hit_cnt[g] <= '0;
      drop_cnt_o <= '0;
    end else if (clr_cnt_i) begin
      for (int g = 0; g < NUM_GROUPS; g++) hit_cnt[g] <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (win_valid && (hit_cnt[win_gid] != '1))
        hit_cnt[win_gid] <= hit_cnt[win_gid] + CNT_WIDTH'(1);
      if (sel_valid && fifo_full && !pop && (drop_cnt_o != '1))
        drop_cnt_o <= drop_cnt_o + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    hit_cnt_o = '0;
    if (32'(hit_cnt_sel_i) < NUM_GROUPS) hit_cnt_o = hit_cnt[hit_cnt_sel_i];
  end

endmodule

// File: tb/tb_pkt_attr_select_queue.sv
// Directed bench for pkt_attr_select_queue: vector table for selection plus
// sequences for backpressure, full-with-pop, saturation and async reset.
module tb_pkt_attr_select_queue;
  import pkt_attr_select_queue_pkg::*;

  localparam int unsigned NG  = 5;
  localparam int unsigned ADW = 135;
  localparam int unsigned FD  = 8;
  localparam int unsigned CW  = 4;
  localparam int unsigned GW  = 3;
  localparam int unsigned LW  = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [NG-1:0]       valid_groups_i;
  logic [NG*ADW-1:0]   data_groups_i;
  logic [NG-1:0]       group_en_i;
  logic [LW-1:0]       fifo_level;
  logic                clr_cnt_i;
  logic [GW-1:0]       hit_cnt_sel_i;
  logic [CW-1:0]       hit_cnt_o;
  logic [CW-1:0]       drop_cnt_o;

  pkt_attr_select_queue_if #(.ADW(ADW), .GW(GW)) oif ();

  pkt_attr_select_queue #(
    .NUM_GROUPS           (NG),
    .ATTRIBUTE_DATA_WIDTH (ADW),
    .FIFO_DEPTH           (FD),
    .CNT_WIDTH            (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_groups_i (valid_groups_i),
    .data_groups_i  (data_groups_i),
    .group_en_i     (group_en_i),
    .out_if         (oif),
    .fifo_level     (fifo_level),
    .clr_cnt_i      (clr_cnt_i),
    .hit_cnt_sel_i  (hit_cnt_sel_i),
    .hit_cnt_o      (hit_cnt_o),
    .drop_cnt_o     (drop_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [NG-1:0] valid;
    logic [NG-1:0] en;
    logic          exp_hit;
    int            exp_gid;
  } vec_t;

  vec_t vt[10];
  int   exp_hits[NG];
  int   q_gid[16];
  int   q_tag[16];

  function automatic logic [ADW-1:0] mk(input int g, input int tag);
    logic [ADW-1:0] r;
    r = '0;
    r[7:0]       = 8'(g);
    r[23:8]      = 16'(tag);
    r[134:119]   = ~16'(tag);
    r[70:63]     = 8'(g * 17 + tag);
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NG-1:0] v, input int tag);
    valid_groups_i = v;
    for (int g = 0; g < NG; g++) data_groups_i[g*ADW +: ADW] = mk(g, tag);
  endtask

  task automatic clear_counters();
    clr_cnt_i = 1'b1;
    step();
    clr_cnt_i = 1'b0;
  endtask

  task automatic read_hit(input string name, input int sel, input int exp);
    hit_cnt_sel_i = GW'(sel);
    #1;
    chk(name, 256'(hit_cnt_o), 256'(exp));
  endtask

  task automatic chk_head(input string name, input int gid, input int tag);
    chk({name, "_valid"}, 256'(oif.out_valid), 256'(1));
    chk({name, "_gid"},   256'(oif.out_group_id), 256'(gid));
    chk({name, "_data"},  256'(oif.out_data), 256'(mk(gid, tag)));
  endtask

  initial begin
    vt[0] = '{5'b00100, 5'b11111, 1'b1, 2};
    vt[1] = '{5'b01110, 5'b11101, 1'b1, 2};
    vt[2] = '{5'b11111, 5'b11111, 1'b1, 0};
    vt[3] = '{5'b01010, 5'b11111, 1'b1, 1};
    vt[4] = '{5'b01000, 5'b10111, 1'b0, 0};
    vt[5] = '{5'b01001, 5'b11110, 1'b1, 3};
    vt[6] = '{5'b00000, 5'b11111, 1'b0, 0};
    vt[7] = '{5'b00011, 5'b00010, 1'b1, 1};
    vt[8] = '{5'b10000, 5'b11111, 1'b1, 4};
    vt[9] = '{5'b11000, 5'b10000, 1'b1, 4};
    for (int g = 0; g < NG; g++) exp_hits[g] = 0;

    reset = 1'b0;
    valid_groups_i = '0;
    data_groups_i = '0;
    group_en_i = '1;
    clr_cnt_i = 1'b0;
    hit_cnt_sel_i = '0;
    oif.out_ready = 1'b1;
    #1 reset = 1'b1;
    #2;
    chk("rst_valid", 256'(oif.out_valid), 256'(0));
    chk("rst_level", 256'(fifo_level), 256'(0));
    chk("rst_data",  256'(oif.out_data), 256'(0));
    chk("rst_gid",   256'(oif.out_group_id), 256'(0));
    chk("rst_drop",  256'(drop_cnt_o), 256'(0));
    chk("rst_hit",   256'(hit_cnt_o), 256'(0));
    step(2);
    @(negedge clk) reset = 1'b0;
    step();

    // Table: single pulse, check N+1 not yet visible, N+2 head, then popped
    for (int i = 0; i < 10; i++) begin
      group_en_i = vt[i].en;
      drive(vt[i].valid, i + 1);
      step();
      valid_groups_i = '0;
      chk($sformatf("v%0d_lat", i), 256'(oif.out_valid), 256'(0));
      step();
      chk($sformatf("v%0d_valid", i), 256'(oif.out_valid), 256'(vt[i].exp_hit));
      if (vt[i].exp_hit) begin
        exp_hits[vt[i].exp_gid]++;
        chk_head($sformatf("v%0d", i), vt[i].exp_gid, i + 1);
      end
      step();
      chk($sformatf("v%0d_drained", i), 256'(fifo_level), 256'(0));
    end
    group_en_i = '1;
    for (int g = 0; g < NG; g++) read_hit($sformatf("tbl_hit%0d", g), g, exp_hits[g]);
    read_hit("sel_oob5", 5, 0);
    read_hit("sel_oob7", 7, 0);
    chk("tbl_drop", 256'(drop_cnt_o), 256'(0));

    // Backpressure: 10 hits into 8 entries drops the last two
    clear_counters();
    oif.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(NG'(1) << (i % NG), 100 + i);
      step();
    end
    valid_groups_i = '0;
    step();
    chk("full_level", 256'(fifo_level), 256'(FD));
    chk("full_drop",  256'(drop_cnt_o), 256'(2));
    chk_head("hold0", 0, 100);
    step();
    chk_head("hold1", 0, 100);
    oif.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk_head($sformatf("drain%0d", i), i % NG, 100 + i);
      step();
    end
    chk("drain_empty", 256'(oif.out_valid), 256'(0));

    // Full FIFO with simultaneous push and pop
    oif.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      q_gid[i] = i % NG;
      q_tag[i] = 200 + i;
      drive(NG'(1) << (i % NG), 200 + i);
      step();
    end
    drive(NG'(1) << 3, 210);
    step();
    chk("pf_full", 256'(fifo_level), 256'(FD));
    valid_groups_i = '0;
    oif.out_ready = 1'b1;
    step();
    oif.out_ready = 1'b0;
    q_gid[8] = 3;
    q_tag[8] = 210;
    chk("pf_level", 256'(fifo_level), 256'(FD));
    chk("pf_drop",  256'(drop_cnt_o), 256'(2));
    oif.out_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      chk_head($sformatf("pf%0d", i), q_gid[i], q_tag[i]);
      step();
    end
    chk("pf_empty", 256'(fifo_level), 256'(0));

    // Saturation, clear precedence
    clear_counters();
    drive(5'b00010, 300);
    step();
    for (int i = 0; i < 20; i++) begin
      drive(5'b00001, 301 + i);
      step();
    end
    valid_groups_i = '0;
    step(2);
    read_hit("sat_hit0", 0, 15);
    read_hit("sat_hit1", 1, 1);
    read_hit("sat_oob", 5, 0);
    chk("sat_drop", 256'(drop_cnt_o), 256'(0));
    chk("sat_empty", 256'(fifo_level), 256'(0));
    hit_cnt_sel_i = '0;
    drive(5'b00001, 400);
    clr_cnt_i = 1'b1;
    step();
    clr_cnt_i = 1'b0;
    valid_groups_i = '0;
    read_hit("clr_hit0", 0, 0);
    step();
    chk_head("clr_rec", 0, 400);
    step();

    // Asynchronous reset with records queued
    oif.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(5'b00100, 500 + i);
      step();
    end
    valid_groups_i = '0;
    step();
    chk("ar_pre_level", 256'(fifo_level), 256'(5));
    read_hit("ar_pre_hit2", 2, 5);
    reset = 1'b1;
    #1;
    chk("ar_valid", 256'(oif.out_valid), 256'(0));
    chk("ar_level", 256'(fifo_level), 256'(0));
    chk("ar_hit2",  256'(hit_cnt_o), 256'(0));
    chk("ar_drop",  256'(drop_cnt_o), 256'(0));
    @(negedge clk) reset = 1'b0;
    oif.out_ready = 1'b1;
    step(2);
    chk("ar_after", 256'(oif.out_valid), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
